emio_led_arb: RTL

Round-robin arbiter that shares the board LED bank between the PS (via EMIO GPIO) and up to three fabric requesters, with a minimum-ownership hold and hold-expiry preemption. Sits in the top level between the PS7 EMIO GPIO vectors, the fabric logic and the `led`/`sw` pins. Also returns synchronized switch state and arbitration status to the PS on `emio_gpio_i`.

---
 rtl/emio_arb_pkg.sv | 18 +
 rtl/emio_sync_debounce.sv | 62 ++++++
 rtl/emio_led_arb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/emio_arb_pkg.sv
// rtl/emio_arb_pkg.sv - shared FSM state, EMIO bit positions and field widths for emio_led_arb
package emio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_e;

    localparam int PS_DATA_LSB = 0;
    localparam int PS_REQ_BIT  = 8;
    localparam int SW_LSB      = 4;
    localparam int SW_W        = 2;
    localparam int OWNER_LSB   = 8;
    localparam int OWNED_BIT   = 10;
    localparam int OWNER_W     = 2;

endpackage

// File: rtl/emio_sync_debounce.sv
// rtl/emio_sync_debounce.sv - multi-stage synchronizer with optional per-bit debounce filter
module emio_sync_debounce #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit DEBOUNCE_EN     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    generate
        if (DEBOUNCE_EN) begin : g_db
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                logic             samp_q;
                logic [CNT_W-1:0] cnt_q;
                logic             out_q;

                // cnt_q counts consecutive samples equal to samp_q, the change sample included
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        samp_q <= 1'b0;
                        cnt_q  <= '0;
                        out_q  <= 1'b0;
                    end else if (sync_q[SYNC_STAGES-1][b] != samp_q) begin
                        samp_q <= sync_q[SYNC_STAGES-1][b];
                        cnt_q  <= CNT_W'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        out_q <= samp_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                assign dout_o[b] = out_q;
            end
        end else begin : g_sync
            assign dout_o = sync_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/emio_led_arb.sv
// rtl/emio_led_arb.sv - round-robin LED bank arbiter between PS EMIO and fabric requesters
// Switch debounce is built only when EMIO_SW_DEBOUNCE_EN is defined.
module emio_led_arb
    import emio_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int LED_W           = 4,
    parameter int HOLD_CYCLES     = 1024,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [63:0]                  emio_gpio_o,
    input  logic [63:0]                  emio_gpio_t,
    output logic [63:0]                  emio_gpio_i,
    input  logic [NUM_REQ-2:0]           req,
    input  logic [(NUM_REQ-1)*LED_W-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    input  logic [1:0]                   sw,
    output logic [LED_W-1:0]             led
);

`ifdef EMIO_SW_DEBOUNCE_EN
    localparam bit SW_DEBOUNCE_EN = 1'b1;
`else
    localparam bit SW_DEBOUNCE_EN = 1'b0;
`endif

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(NUM_REQ - 1);
    localparam logic [OWNER_W:0]   NUM_REQ_W = (OWNER_W + 1)'(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [LED_W:0]      ps_raw, ps_s;
    logic [SW_W-1:0]     sw_s;
    logic [NUM_REQ-1:0]  req_vec, req_rot, owner_onehot;
    logic                found;
    logic [OWNER_W:0]    win_sum;
    logic [OWNER_W-1:0]  winner;
    logic                owner_req, others_pending;
    logic                unused_bits;

    assign ps_raw = {emio_gpio_o[PS_REQ_BIT] & ~emio_gpio_t[PS_REQ_BIT],
                     emio_gpio_o[PS_DATA_LSB +: LED_W]};

    assign unused_bits = ^{emio_gpio_o[63:PS_REQ_BIT+1], emio_gpio_o[PS_REQ_BIT-1:LED_W],
                           emio_gpio_t[63:PS_REQ_BIT+1], emio_gpio_t[PS_REQ_BIT-1:0]};

    emio_sync_debounce #(
        .WIDTH          (LED_W + 1),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEBOUNCE_EN    (1'b0)
    ) u_ps_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din_i (ps_raw),
        .dout_o(ps_s)
    );

    emio_sync_debounce #(
        .WIDTH          (SW_W),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEBOUNCE_EN    (SW_DEBOUNCE_EN)
    ) u_sw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din_i (sw),
        .dout_o(sw_s)
    );

    function automatic logic [LED_W-1:0] sel_data(
        input logic [OWNER_W-1:0]           idx,
        input logic [LED_W-1:0]             ps_data,
        input logic [(NUM_REQ-1)*LED_W-1:0] fab_data
    );
        logic [LED_W-1:0] d;
        d = ps_data;
        for (int k = 1; k < NUM_REQ; k++) begin
            if (idx == OWNER_W'(k)) begin
                d = fab_data[(k-1)*LED_W +: LED_W];
            end
        end
        return d;
    endfunction

    assign req_vec        = {req, ps_s[LED_W]};
    assign owner_onehot   = NUM_REQ'(1) << owner_q;
    assign owner_req      = |(req_vec & owner_onehot);
    assign others_pending = |(req_vec & ~owner_onehot);

    // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit
    assign req_rot = NUM_REQ'({req_vec, req_vec} >> rr_ptr_q);

    always_comb begin
        found   = 1'b0;
        win_sum = {1'b0, rr_ptr_q};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                win_sum = {1'b0, rr_ptr_q} + (OWNER_W + 1)'(i);
            end
        end
        if (win_sum >= NUM_REQ_W) begin
            win_sum = win_sum - NUM_REQ_W;
        end
        winner = win_sum[OWNER_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        led_d      = led_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                led_d   = '0;
                if (|req_vec) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                grant_d = '0;
                if (found) begin
                    grant_d    = NUM_REQ'(1) << winner;
                    led_d      = sel_data(winner, ps_s[LED_W-1:0], req_data);
                    owner_d    = winner;
                    hold_cnt_d = '0;
                    rr_ptr_d   = (winner == LAST_IDX) ? '0 : winner + 1'b1;
                    state_d    = ST_OWN;
                end else begin
                    led_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                led_d = sel_data(owner_q, ps_s[LED_W-1:0], req_data);
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // Release takes priority over preemption when both apply
                if (!owner_req) begin
                    grant_d = '0;
                    if (others_pending) begin
                        led_d   = led_q;
                        state_d = ST_ARB;
                    end else begin
                        led_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (hold_cnt_q == HOLD_MAX && others_pending) begin
                    grant_d = '0;
                    led_d   = led_q;
                    state_d = ST_ARB;
                end
            end
            default: begin
                grant_d = '0;
                led_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            led_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            led_q      <= led_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        emio_gpio_i                         = '0;
        emio_gpio_i[SW_LSB +: SW_W]         = sw_s;
        emio_gpio_i[OWNER_LSB +: OWNER_W]   = owner_q;
        emio_gpio_i[OWNED_BIT]              = (state_q == ST_OWN);
    end

    assign grant = grant_q;
    assign led   = led_q;

endmodule
